mult_4bit_seq: RTL and testbench



---
 rtl/mult_4bit_seq_pkg.sv | 16 +
 rtl/mult_4bit_seq_adder.sv | 19 +
 rtl/mult_4bit_seq.sv | 104 ++++++++++
 tb/tb_mult_4bit_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mult_4bit_seq_pkg.sv
// Shared definitions for the sequential 4x4 shift-and-add multiplier.
// Holds the state encoding, operand width and iteration count.
package mult_4bit_seq_pkg;

   localparam int WIDTH = 4;
   localparam int ITER  = 4;

   localparam logic [2:0] CNT_LAST = 3'(ITER - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mult_4bit_seq_adder.sv
// Plain 4-bit ripple adder with carry-in.
// The multiplier uses it as the partial-product adder for each iteration.
module adder_4bit
   import mult_4bit_seq_pkg::*;
(
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C0,
   output logic [WIDTH-1:0] SUM,
   output logic             Overflow
);

   logic [WIDTH:0] total;

   assign total    = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, C0};
   assign SUM      = total[WIDTH-1:0];
   assign Overflow = total[WIDTH];

endmodule

// File: rtl/mult_4bit_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier: IDLE -> RUN (4 iterations) -> DONE.
// Handshake: start is accepted only in IDLE or DONE; done pulses one cycle with product valid.
module mult_4bit_seq
   import mult_4bit_seq_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [2*WIDTH-1:0] product
);

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic                 c_q, c_d;
   logic [2:0]           cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic                 busy_q, done_q;

   logic [WIDTH-1:0]     add_sum;
   logic                 add_ovf;
   logic [WIDTH-1:0]     post_acc;
   logic                 post_c;

   adder_4bit u_adder (
      .A        (acc_q),
      .B        (m_q),
      .C0       (1'b0),
      .SUM      (add_sum),
      .Overflow (add_ovf)
   );

   // c_q is always zero entering an iteration, so the skip path equals {0, A}.
   assign post_c   = q_q[0] ? add_ovf : c_q;
   assign post_acc = q_q[0] ? add_sum : acc_q;

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      acc_d   = acc_q;
      q_d     = q_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (start) begin
               m_d     = a;
               q_d     = b;
               acc_d   = '0;
               c_d     = 1'b0;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            acc_d = {post_c, post_acc[WIDTH-1:1]};
            q_d   = {post_acc[0], q_q[WIDTH-1:1]};
            c_d   = 1'b0;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == CNT_LAST) begin
               prod_d  = {acc_d, q_d};
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         m_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         prod_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         busy_q  <= (state_d == ST_RUN);
         done_q  <= (state_d == ST_DONE);
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = prod_q;

endmodule

// File: tb/tb_mult_4bit_seq.sv
// Self-checking bench for mult_4bit_seq: timing/product model plus directed literal checks.
module tb_mult_4bit_seq;

   logic       clk;
   logic       reset;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       busy;
   logic       done;
   logic [7:0] product;

   int n_checks = 0;
   int n_pass   = 0;
   bit check_en = 0;

   mult_4bit_seq dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // model: acceptance takes 4 busy cycles, then a one-cycle done with a*b
   logic [7:0] exp_q[$];
   logic       m_busy = 1'b0;
   logic       m_done = 1'b0;
   logic [7:0] m_prod = 8'h00;
   int         m_left = 0;

   always @(posedge clk) begin
      if (reset) begin
         exp_q.delete();
         m_busy = 1'b0;
         m_done = 1'b0;
         m_prod = 8'h00;
         m_left = 0;
      end else if (!m_busy && start) begin
         exp_q.push_back(8'(a) * 8'(b));
         m_busy = 1'b1;
         m_done = 1'b0;
         m_left = 4;
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_prod = exp_q.pop_front();
         end
      end else begin
         m_done = 1'b0;
      end
   end

   // compare process
   always @(negedge clk) begin
      if (check_en) begin
         check("cyc_busy", {7'd0, busy}, {7'd0, m_busy});
         check("cyc_done", {7'd0, done}, {7'd0, m_done});
         check("cyc_product", product, m_prod);
      end
   end

   // driver tasks
   task automatic wait_done(output int cycles);
      cycles = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            cycles = i;
            break;
         end
      end
      if (cycles == 0) check("done_timeout", {7'd0, done}, 8'd1);
   endtask

   task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                         input logic [7:0] exp, input string name);
      int cyc;
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc);
      check({name, "_latency"}, 8'(cyc + 1), 8'd5);
      check(name, product, exp);
      @(negedge clk);
      check({name, "_hold"}, product, exp);
      check({name, "_done_fell"}, {7'd0, done}, 8'd0);
   endtask

   initial begin
      int cyc;
      reset = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check_en = 1;
      @(negedge clk);
      check("rst_busy", {7'd0, busy}, 8'd0);
      check("rst_done", {7'd0, done}, 8'd0);
      check("rst_product", product, 8'h00);
      repeat (10) @(negedge clk);
      check("idle_product", product, 8'h00);

      run_op(4'd13, 4'd11, 8'h8F, "13x11");
      run_op(4'hF,  4'hF,  8'hE1, "15x15");
      run_op(4'h0,  4'h9,  8'h00, "0x9");
      run_op(4'h7,  4'h0,  8'h00, "7x0");

      // start held high: back-to-back operations taken in DONE
      @(negedge clk);
      a = 4'd3; b = 4'd5; start = 1'b1;
      wait_done(cyc);
      check("b2b_first_latency", 8'(cyc), 8'd5);
      check("b2b_first", product, 8'h0F);
      @(negedge clk);
      check("b2b_busy_again", {7'd0, busy}, 8'd1);
      a = 4'd2; b = 4'd2;
      wait_done(cyc);
      check("b2b_spacing", 8'(cyc + 1), 8'd5);
      check("b2b_second", product, 8'h0F);
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc);
      check("b2b_third", product, 8'h04);

      // start during RUN is ignored
      @(negedge clk);
      a = 4'd9; b = 4'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 4'd1; b = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 4'd0; b = 4'd0;
      wait_done(cyc);
      check("ignore_start", product, 8'h51);

      // reset mid-RUN aborts the operation
      @(negedge clk);
      a = 4'd6; b = 4'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", {7'd0, busy}, 8'd0);
      check("abort_done", {7'd0, done}, 8'd0);
      check("abort_product", product, 8'h00);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("abort_no_done", {7'd0, done}, 8'd0);
      end
      run_op(4'd6, 4'd7, 8'h2A, "6x7");

      repeat (3) @(negedge clk);
      check_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
